// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI initiator controller.
package pci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ABORT,
    TURN
  } state_t;

  localparam int unsigned DEVSEL_TIMEOUT = 5;
  localparam logic [3:0]  MEM_READ       = 4'b0110;
  localparam logic [3:0]  MEM_WRITE      = 4'b0111;

  // A zero length request still performs one data phase.
  function automatic logic [3:0] phase_count(input logic [3:0] len);
    return (len == 4'd0) ? 4'd1 : len;
  endfunction

endpackage

// File: rtl/pci_master_ctrl_if.sv
// PCI bus-side signals between the initiator and a target.
interface pci_master_ctrl_if;

  logic        frame;
  logic        irdy;
  logic [3:0]  cbe;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [31:0] ad_in;
  logic        devsel;
  logic        trdy;

  modport master (
    output frame, irdy, cbe, ad_out, ad_oe,
    input  ad_in, devsel, trdy
  );

  modport slave (
    input  frame, irdy, cbe, ad_out, ad_oe,
    output ad_in, devsel, trdy
  );

endinterface

// File: rtl/pci_devsel_timer.sv
// Devsel watchdog: 3-bit saturating counter with clear/enable.
module pci_devsel_timer
  import pci_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic timeout
);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Flags the edge on which the counter reaches the limit, so the FSM
  // leaves DATA on that same edge.
  assign timeout = en && (cnt == 3'(DEVSEL_TIMEOUT - 1));

endmodule

// File: rtl/pci_master_ctrl.sv
// PCI initiator: address phase, burst data phases with wait states,
// master abort on devsel timeout, and a turnaround cycle.
module pci_master_ctrl
  import pci_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [3:0]            cmd,
  input  logic [31:0]           addr,
  input  logic [3:0]            len,
  input  logic [31:0]           wdata,
  pci_master_ctrl_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  abort,
  output logic                  data_ack,
  output logic                  rvalid,
  output logic [31:0]           rdata
);

  state_t      state;
  logic [3:0]  remaining;
  logic        wr;
  logic        devsel_seen;
  logic        frame_r;
  logic        irdy_r;
  logic [3:0]  cbe_r;
  logic [31:0] ad_out_r;
  logic        ad_oe_r;

  logic        phase_done;
  logic        timer_clear;
  logic        timer_en;
  logic        timeout;

  assign bus.frame  = frame_r;
  assign bus.irdy   = irdy_r;
  assign bus.cbe    = cbe_r;
  assign bus.ad_out = ad_out_r;
  assign bus.ad_oe  = ad_oe_r;

  assign phase_done  = (state == DATA) && !irdy_r && !bus.trdy && !bus.devsel;
  assign timer_clear = (state != DATA);
  assign timer_en    = (state == DATA) && bus.devsel && !devsel_seen;

  pci_devsel_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .en      (timer_en),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      wr          <= 1'b0;
      devsel_seen <= 1'b0;
      frame_r     <= 1'b1;
      irdy_r      <= 1'b1;
      cbe_r       <= '1;
      ad_out_r    <= '0;
      ad_oe_r     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
      data_ack    <= 1'b0;
      rvalid      <= 1'b0;
      rdata       <= '0;
    end else begin
      done     <= 1'b0;
      abort    <= 1'b0;
      data_ack <= 1'b0;
      rvalid   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state     <= ADDR;
            wr        <= cmd[0];
            remaining <= phase_count(len);
            frame_r   <= 1'b0;
            irdy_r    <= 1'b1;
            cbe_r     <= cmd;
            ad_out_r  <= addr;
            ad_oe_r   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ADDR: begin
          state       <= DATA;
          devsel_seen <= 1'b0;
          irdy_r      <= 1'b0;
          cbe_r       <= '0;
          ad_oe_r     <= wr;
          ad_out_r    <= wr ? wdata : '0;
          frame_r     <= (remaining == 4'd1);
        end
        DATA: begin
          if (!bus.devsel) devsel_seen <= 1'b1;
          if (phase_done) begin
            remaining <= remaining - 4'd1;
            if (wr) begin
              data_ack <= 1'b1;
            end else begin
              rdata  <= bus.ad_in;
              rvalid <= 1'b1;
            end
            if (remaining == 4'd1) begin
              state    <= TURN;
              done     <= 1'b1;
              frame_r  <= 1'b1;
              irdy_r   <= 1'b1;
              ad_oe_r  <= 1'b0;
              cbe_r    <= '1;
              ad_out_r <= '0;
            end else begin
              // frame rises with the last phase, one phase ahead of its completion.
              frame_r <= (remaining == 4'd2);
              if (wr) ad_out_r <= wdata;
            end
          end else if (timeout) begin
            state    <= ABORT;
            abort    <= 1'b1;
            frame_r  <= 1'b1;
            irdy_r   <= 1'b1;
            ad_oe_r  <= 1'b0;
            cbe_r    <= '1;
            ad_out_r <= '0;
          end
        end
        ABORT: begin
          state <= TURN;
        end
        TURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pci_master_ctrl.md
PCI_MASTER_CTRL -- requirements
Module: pci_master_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: req  in  1  start-transaction strobe, sampled only in IDLE.
REQ-004 SHALL have: cmd  in  4  PCI command, latched with req; cmd[0]=1 write, 0 read.
REQ-005 SHALL have: addr  in  32  target address, latched with req.
REQ-006 SHALL have: len  in  4  data-phase count, latched with req; 0 treated as 1.
REQ-007 SHALL have: wdata  in  32  current write word, driven onto ad_out during write data phases.
REQ-008 SHALL have: ad_in  in  32  AD bus sampled during read data phases.
REQ-009 SHALL have: devsel, trdy  in  1 each  active-low target responses.
REQ-010 SHALL have: frame, irdy  out  1 each  active-low initiator controls.
REQ-011 SHALL have: cbe  out  4  C/BE#; ad_out  out  32; ad_oe  out  1 AD drive enable.
REQ-012 SHALL have: busy, done, abort, data_ack, rvalid  out  1 each; rdata  out  32.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA, ABORT, TURN.
REQ-014 IDLE: frame=1, irdy=1, ad_oe=0, busy=0; req=1 latches cmd/addr/len, next ADDR.
REQ-015 ADDR, exactly 1 cycle: frame=0, irdy=1, ad_out=addr, cbe=cmd, ad_oe=1, busy=1; next DATA.
REQ-016 DATA: irdy=0, cbe=4'b0000, ad_oe=cmd[0], ad_out=wdata when writing.
REQ-017 frame SHALL be 0 in DATA while remaining>1 and 1 while remaining==1 (last phase).
REQ-018 A data phase completes on an edge sampling irdy=0, trdy=0, devsel=0; trdy=0 with devsel=1 is ignored.
REQ-019 On each completion: remaining decrements; write -> data_ack=1 for one cycle; read -> rdata=ad_in, rvalid=1 for one cycle.
REQ-020 Wait states: while trdy=1 in DATA, all outputs hold, remaining unchanged, no pulses.
REQ-021 Completion with remaining==1 SHALL move to TURN and pulse done=1 for one cycle.
REQ-022 Devsel timeout: counter clears on DATA entry and increments each DATA cycle with devsel=1 until devsel is first seen 0.
REQ-023 If the counter reaches DEVSEL_TIMEOUT=5 before devsel is seen 0 -> ABORT (master abort).
REQ-024 ABORT, 1 cycle: frame=1, irdy=1, ad_oe=0, abort=1; next TURN; done not pulsed.
REQ-025 TURN, 1 cycle: frame=1, irdy=1, ad_oe=0, busy=1; next IDLE.
REQ-026 req while busy=1 SHALL be ignored and not queued.
REQ-027 Once devsel is seen 0, later devsel=1 SHALL NOT trigger abort.

Reset
REQ-028 rst=1 SHALL immediately force IDLE.
REQ-029 Reset values: frame=1, irdy=1, cbe=4'hF, ad_out=0, ad_oe=0, busy=0, done=0, abort=0, data_ack=0, rvalid=0, rdata=0, counters 0.
REQ-030 Reset mid-transaction SHALL discard the transfer with no done or abort pulse.

Structure
REQ-031 Package pci_pkg SHALL hold the state enum, DEVSEL_TIMEOUT=5, MEM_READ=4'b0110, MEM_WRITE=4'b0111.
REQ-032 Sub-module pci_devsel_timer (3-bit saturating counter, clear/enable, timeout flag) SHALL implement the devsel watchdog.

Verification
REQ-033 Write, len=1, addr=32'h1000, target devsel=0/trdy=0 on first DATA cycle -> frame low 1 cycle, one data_ack, done one cycle later, busy low after TURN.
REQ-034 Read, len=4, ad_in=32'hA0..A3 per phase, no wait states -> 4 consecutive rvalid with rdata A0..A3; frame high only in last phase; done=1.
REQ-035 Write, len=2, trdy held 1 for 3 cycles before each phase -> irdy stays 0; ad_out holds wdata; exactly 2 data_ack.
REQ-036 Read, len=3, devsel held 1 -> abort=1 on the 6th cycle after ADDR; no rvalid; frame/irdy=1; no done.
REQ-037 rst asserted during 2nd phase of a len=4 read -> all outputs at reset values the same instant; subsequent req starts cleanly.
REQ-038 req pulsed during DATA, and len=0 -> second req ignored; len=0 performs exactly 1 data phase.
